// File: rtl/miner_nonce_sched.sv
// miner_nonce_sched
//   Streams candidate nonces for one mining job into a pipelined BLAKE3
//   compression core and reports hashes that meet the job target.
//   Each in-flight candidate is tracked by its own latency-matched tag,
//   because the core's valid cannot follow back-to-back issues.
//
// Ports
//   Clk, Rst_I           clock (rising edge), async active-high reset
//   Job_*                job offer (ready/valid) with H, message template,
//                        target, nonce base and nonce count
//   Abort_I              stop the current job and discard in-flight results
//   Core_*               candidate stream to the core / hash back from it
//   Found_*              one-entry hit slot (ready/valid)
//   Done_O, Aborted_O    job-retired pulse, qualified by abort
//   Drop_O               sticky: a hit was lost since the last job accept
//   Busy_O               scheduler not idle
//
// 8x32 and 16x32 buses are flattened; word i lives at [32*i +: 32].
module miner_nonce_sched #(
  parameter int unsigned CORE_LAT   = 76,
  parameter int unsigned NONCE_WORD = 3
) (
  input  logic         Clk,
  input  logic         Rst_I,
  input  logic         Job_Vld_I,
  output logic         Job_Rdy_O,
  input  logic [255:0] Job_H_I,
  input  logic [511:0] Job_Msg_I,
  input  logic [31:0]  Job_Target_I,
  input  logic [31:0]  Job_NonceBase_I,
  input  logic [31:0]  Job_NonceCnt_I,
  input  logic         Abort_I,
  output logic         Core_Strt_O,
  output logic [255:0] Core_H_O,
  output logic [511:0] Core_Msg_O,
  input  logic [255:0] Core_H_I,
  output logic         Found_Vld_O,
  input  logic         Found_Rdy_I,
  output logic [31:0]  Found_Nonce_O,
  output logic [255:0] Found_Hash_O,
  output logic         Done_O,
  output logic         Aborted_O,
  output logic         Drop_O,
  output logic         Busy_O
);

  localparam int unsigned CW = $clog2(CORE_LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [255:0]        h_q;
  logic [511:0]        msg_q;
  logic [31:0]         tgt_q, base_q, cnt_q, idx_q, idx_d;
  logic [CORE_LAT-1:0] tv_q, tv_d;
  logic [31:0]         tn_q [CORE_LAT];
  logic [CW-1:0]       infl_q, infl_d;
  logic                fv_q;
  logic [31:0]         fn_q;
  logic [255:0]        fh_q;
  logic                done_q, done_d;
  logic                abd_q;
  logic                drop_q;

  logic        idle, accept, abort, issue, pop_raw, pop, hit, load;
  logic [31:0] nonce;
  logic [511:0] msg_mux;

  assign idle    = (state_q == S_IDLE);
  assign accept  = idle && Job_Vld_I;
  // Abort only matters while a job is live; the Done cycle itself already
  // retires the job, so a late abort there is ignored.
  assign abort   = Abort_I && !idle && !done_q;
  assign issue   = (state_q == S_ISSUE) && !Abort_I;
  assign nonce   = base_q + idx_q;
  assign pop_raw = tv_q[CORE_LAT-1];
  assign pop     = pop_raw && !abort;
  assign hit     = pop && (Core_H_I[31:0] <= tgt_q);
  assign load    = hit && (!fv_q || Found_Rdy_I);

  always_comb begin
    msg_mux = msg_q;
    msg_mux[NONCE_WORD*32 +: 32] = nonce;
  end

  always_comb begin
    tv_d = abort ? '0 : {tv_q[CORE_LAT-2:0], issue};
  end

  always_comb begin
    infl_d = infl_q;
    if (abort) begin
      infl_d = '0;
    end else if (issue && !pop_raw) begin
      infl_d = infl_q + CW'(1);
    end else if (!issue && pop_raw) begin
      infl_d = infl_q - CW'(1);
    end
  end

  // Done is registered off the next in-flight count, so the pulse lands one
  // cycle after the last pop (or after the abort) and the FSM leaves DRAIN
  // on the pulse itself.
  always_comb begin
    done_d = abort || ((state_q == S_DRAIN) && !done_q && (infl_d == '0));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (Job_Vld_I) begin
          idx_d   = '0;
          state_d = (Job_NonceCnt_I == '0) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (Abort_I) begin
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + 32'd1;
          if (idx_q == cnt_q - 32'd1) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (done_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst_I) begin
    if (Rst_I) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      msg_q   <= '0;
      tgt_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tv_q    <= '0;
      infl_q  <= '0;
      fv_q    <= 1'b0;
      fn_q    <= '0;
      fh_q    <= '0;
      done_q  <= 1'b0;
      abd_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tv_q    <= tv_d;
      infl_q  <= infl_d;
      done_q  <= done_d;
      abd_q   <= abort;
      if (accept) begin
        h_q    <= Job_H_I;
        msg_q  <= Job_Msg_I;
        tgt_q  <= Job_Target_I;
        base_q <= Job_NonceBase_I;
        cnt_q  <= Job_NonceCnt_I;
      end
      if (load) begin
        fv_q <= 1'b1;
        fn_q <= tn_q[CORE_LAT-1];
        fh_q <= Core_H_I;
      end else if (Found_Rdy_I) begin
        fv_q <= 1'b0;
      end
      if (accept) begin
        drop_q <= 1'b0;
      end
      if (hit && !load) begin
        drop_q <= 1'b1;
      end
    end
  end

  // Nonce half of the tag pipe; only the valid bits need reset.
  always_ff @(posedge Clk) begin
    tn_q[0] <= nonce;
    for (int unsigned i = 1; i < CORE_LAT; i++) begin
      tn_q[i] <= tn_q[i-1];
    end
  end

  assign Job_Rdy_O     = idle;
  assign Busy_O        = !idle;
  assign Core_Strt_O   = issue;
  assign Core_H_O      = h_q;
  assign Core_Msg_O    = msg_mux;
  assign Found_Vld_O   = fv_q;
  assign Found_Nonce_O = fn_q;
  assign Found_Hash_O  = fh_q;
  assign Done_O        = done_q;
  assign Aborted_O     = abd_q;
  assign Drop_O        = drop_q;

endmodule

// File: doc/miner_nonce_sched.md
# miner_nonce_sched

Job scheduler that sits in front of the pipelined BLAKE3 compression core. It accepts one mining job and streams one candidate nonce per cycle into the core. It tracks every in-flight candidate with its own latency-matched tag pipeline, because the core's single-shot valid cannot track back-to-back issues. It compares each returning hash against the job target and reports hits over a ready/valid result port.

## Interface
Parameters:
- CORE_LAT, 76, cycles from a core input sample (Core_Strt_O high) to its hash on Core_H_I
- NONCE_WORD, 3, message word index (0-15) replaced by the nonce

Ports:
- Clk  in  1  clock; all logic on rising edge
- Rst_I  in  1  reset, asynchronous, active-high
- Job_Vld_I  in  1  job offer
- Job_Rdy_O  out  1  job accepted when Job_Vld_I & Job_Rdy_O
- Job_H_I  in  8x32  chaining value for the job
- Job_Msg_I  in  16x32  message template
- Job_Target_I  in  32  hit when Core_H_I[0] <= target (unsigned)
- Job_NonceBase_I  in  32  first nonce
- Job_NonceCnt_I  in  32  number of nonces; 0 = empty job
- Abort_I  in  1  stop issuing the current job
- Core_Strt_O  out  1  candidate valid to core
- Core_H_O  out  8x32  latched Job_H_I
- Core_Msg_O  out  16x32  template with word NONCE_WORD = current nonce
- Core_H_I  in  8x32  core hash output
- Found_Vld_O  out  1  hit available
- Found_Rdy_I  in  1  hit consumed when Found_Vld_O & Found_Rdy_I
- Found_Nonce_O  out  32  nonce of the hit
- Found_Hash_O  out  8x32  hash of the hit
- Done_O  out  1  one-cycle pulse; job fully retired
- Aborted_O  out  1  qualifies Done_O; job ended by abort
- Drop_O  out  1  sticky; at least one hit lost since the last job accept
- Busy_O  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE: Job_Rdy_O=1. On accept, latch H, Msg, target, base, and count. Clear idx and Drop_O. Go to ISSUE, or to DRAIN if count=0.
  - ISSUE: Core_Strt_O=1 every cycle. Nonce = (base+idx) mod 2^32, so wrap past 0xFFFFFFFF is legal. Push {1, nonce} into the tag pipe and increment idx. After the issue with idx=count-1, go to DRAIN.
  - DRAIN: no issue. Stay until the in-flight counter reaches 0. Then pulse Done_O and go to IDLE.
- Abort_I in ISSUE:
  - No issue that cycle; go to DRAIN.
  - Clear all tag-pipe valid bits and the in-flight counter, so in-flight results are discarded.
  - Done_O and Aborted_O pulse on the next cycle.
- Abort_I in DRAIN: same discard, then Done_O and Aborted_O next cycle.
- Abort_I in IDLE: ignored, including when it coincides with a job accept; the job is still accepted.
- Tag pipe: CORE_LAT-deep shift register of {valid, nonce}, advancing every cycle. The in-flight counter increments on push and decrements on a valid pop; both may happen in one cycle, leaving it unchanged.
- Compare: a valid pop with Core_H_I[0] <= target is a hit. Target 0xFFFFFFFF makes every candidate a hit.
- One-entry result slot:
  - A hit loads the slot if the slot is empty, or is being consumed in the same cycle.
  - Otherwise the hit is dropped and Drop_O is set.
  - Found_* hold stable while Found_Vld_O is high and Found_Rdy_I is low.
- Result slot persists across jobs; only Rst_I clears it.

## Timing
- Reset values:
  - Job_Rdy_O=1.
  - Core_Strt_O, Found_Vld_O, Done_O, Aborted_O, Drop_O, Busy_O all 0.
  - Data outputs 0; tag valid bits 0; state IDLE.
- Job accepted at edge T: first Core_Strt_O in cycle T+1, nonce k in cycle T+1+k.
- Candidate issued in cycle S: compared in cycle S+CORE_LAT; Found_Vld_O high from S+CORE_LAT+1.
- Last pop in cycle R: Done_O in R+1, Job_Rdy_O in R+2.
- Empty job: Done_O at T+2.
- Throughput: one nonce per cycle sustained; issue never stalls on a full result slot.
- Reset asserted mid-job: immediate return to reset values; core results still in flight are ignored because the tag valid bits are clear.

## Test plan
- Base=0x10, count=4, target=0xFFFFFFFF, Found_Rdy_I=1:
  - Core_Strt_O high 4 cycles with nonces 0x10-0x13 in word 3.
  - Four hits at CORE_LAT+1 cycles after each issue.
  - Done_O at T+4+CORE_LAT+1; Drop_O=0.
- Base=0xFFFFFFFE, count=3: nonces 0xFFFFFFFE, 0xFFFFFFFF, 0x0 issued in order.
- Count=0: no Core_Strt_O; Done_O at T+2; Aborted_O=0.
- Target=0xFFFFFFFF, count=3, Found_Rdy_I=0:
  - First hit held in the slot; second and third dropped; Drop_O=1.
  - Raising Found_Rdy_I yields the first nonce only.
- Abort_I in the 5th issue cycle of a count=100 job:
  - Exactly 4 issues; no Found_Vld_O from them.
  - Done_O and Aborted_O pulse the following cycle.
  - Next job accepted cleanly.
- Rst_I asserted during ISSUE with hits in flight: all outputs return to reset values; no Found_Vld_O after release.
